// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
//
// Purpose: default sizing constants, the arbiter state type and a small index-width
// helper shared by the arbiter top and its round-robin picker.
// Ports: none (package).
package data_mem_arbiter_pkg;

   localparam int CORE_COUNT = 3;
   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 12;
   localparam int LOCK_MAX   = 4;

   typedef enum logic {
      ARB,
      LOCKED
   } arb_state_t;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_priority_picker.sv
// rtl/data_mem_arbiter_rr_priority_picker.sv - combinational round-robin request picker
//
// Purpose: picks the first asserted request scanning ptr_i, ptr_i+1, ... with wrap.
// Ports:
//   req_i        [N-1:0]  request vector
//   ptr_i        [IW-1:0] index where the scan starts (must be < N)
//   winner_oh_o  [N-1:0]  one-hot winner, zero when no request
//   winner_idx_o [IW-1:0] winner index, zero when no request
//   valid_o               at least one request present
module rr_priority_picker #(
   parameter  int N  = data_mem_arbiter_pkg::CORE_COUNT,
   localparam int IW = data_mem_arbiter_pkg::idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  winner_oh_o,
   output logic [IW-1:0] winner_idx_o,
   output logic          valid_o
);
   import data_mem_arbiter_pkg::*;

   always_comb begin
      int            c;
      logic [IW-1:0] cidx;
      winner_oh_o  = '0;
      winner_idx_o = '0;
      valid_o      = 1'b0;
      c            = 0;
      cidx         = '0;
      for (int i = 0; i < N; i++) begin
         // Wrap by a single subtraction: ptr_i < N and i < N keep the sum below 2N.
         c = int'(ptr_i) + i;
         if (c >= N) begin
            c = c - N;
         end
         cidx = c[IW-1:0];
         if (!valid_o && req_i[cidx]) begin
            valid_o           = 1'b1;
            winner_idx_o      = cidx;
            winner_oh_o[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin data memory arbiter with short atomic lock
//
// Purpose: shares one synchronous-read data memory between CORE_COUNT cores, one
// access per cycle, round-robin, with a bounded lock for read-modify-write sequences.
// Ports:
//   clk, rstN            clock; synchronous active-low reset
//   req/lock/wrEn        per-core request, lock hold, write (1) / read (0)
//   addr/wrData          per-core address and write data
//   gnt                  one-hot grant for this cycle (combinational)
//   rdValid/rdData       one-hot read return owner and data, one cycle after a read grant
//   memAddr/memWrData/memWrEn  to the data memory (zero with no grant)
//   memRdData            from the data memory, valid one cycle after memAddr
module data_mem_arbiter #(
   parameter int CORE_COUNT = data_mem_arbiter_pkg::CORE_COUNT,
   parameter int ADDR_WIDTH = data_mem_arbiter_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = data_mem_arbiter_pkg::DATA_WIDTH,
   parameter int LOCK_MAX   = data_mem_arbiter_pkg::LOCK_MAX
) (
   input  logic                                  clk,
   input  logic                                  rstN,
   input  logic [CORE_COUNT-1:0]                 req,
   input  logic [CORE_COUNT-1:0]                 lock,
   input  logic [CORE_COUNT-1:0]                 wrEn,
   input  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0] addr,
   input  logic [CORE_COUNT-1:0][DATA_WIDTH-1:0] wrData,
   output logic [CORE_COUNT-1:0]                 gnt,
   output logic [CORE_COUNT-1:0]                 rdValid,
   output logic [DATA_WIDTH-1:0]                 rdData,
   output logic [ADDR_WIDTH-1:0]                 memAddr,
   output logic [DATA_WIDTH-1:0]                 memWrData,
   output logic                                  memWrEn,
   input  logic [DATA_WIDTH-1:0]                 memRdData
);
   import data_mem_arbiter_pkg::*;

   localparam int            IW         = idx_width(CORE_COUNT);
   localparam int            CW         = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
   localparam logic [IW-1:0] LAST_IDX   = IW'(CORE_COUNT - 1);

   arb_state_t      state_q,    state_d;
   logic [IW-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [IW-1:0]   owner_q,    owner_d;
   logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
   logic            rd_valid_q, rd_valid_d;
   logic [IW-1:0]   rd_owner_q, rd_owner_d;

   logic [CORE_COUNT-1:0] pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_valid;

   logic                  gnt_any;
   logic [IW-1:0]         gnt_idx;
   logic [CORE_COUNT-1:0] gnt_oh;

   rr_priority_picker #(
      .N (CORE_COUNT)
   ) u_picker (
      .req_i        (req),
      .ptr_i        (rr_ptr_q),
      .winner_oh_o  (pick_oh),
      .winner_idx_o (pick_idx),
      .valid_o      (pick_valid)
   );

   // Grant selection and state transitions.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      gnt_any    = 1'b0;
      gnt_idx    = '0;
      gnt_oh     = '0;

      case (state_q)
         ARB: begin
            if (pick_valid) begin
               gnt_any  = 1'b1;
               gnt_idx  = pick_idx;
               gnt_oh   = pick_oh;
               rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
               // A one-cycle lock budget is used up by this grant, so no lock is entered.
               if (lock[pick_idx] && (LOCK_MAX > 1)) begin
                  state_d    = LOCKED;
                  owner_d    = pick_idx;
                  lock_cnt_d = CW'(1);
               end
            end
         end
         LOCKED: begin
            if (req[owner_q]) begin
               gnt_any         = 1'b1;
               gnt_idx         = owner_q;
               gnt_oh[owner_q] = 1'b1;
               lock_cnt_d      = lock_cnt_q + 1'b1;
               // The grant that brings the count to LOCK_MAX is the last one of the burst.
               if (!lock[owner_q] || (lock_cnt_d >= LOCK_MAX_C)) begin
                  state_d = ARB;
               end
            end else begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase

      // Nothing reaches the memory while reset is held.
      if (!rstN) begin
         gnt_any = 1'b0;
         gnt_oh  = '0;
      end
   end

   assign rd_valid_d = gnt_any & ~wrEn[gnt_idx];
   assign rd_owner_d = gnt_any ? gnt_idx : rd_owner_q;

   assign gnt       = gnt_oh;
   assign memAddr   = gnt_any ? addr[gnt_idx]   : '0;
   assign memWrData = gnt_any ? wrData[gnt_idx] : '0;
   assign memWrEn   = gnt_any & wrEn[gnt_idx];

   // Read return; masked during reset so a pending read never surfaces.
   always_comb begin
      rdValid = '0;
      if (rstN && rd_valid_q) begin
         rdValid[rd_owner_q] = 1'b1;
      end
   end

   assign rdData = (rstN && rd_valid_q) ? memRdData : '0;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q    <= ARB;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         rd_owner_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 12;
   localparam int LM = 4;

   logic                  clk = 1'b0;
   logic                  rstN;
   logic [N-1:0]          req, lock, wrEn;
   logic [N-1:0][AW-1:0]  addr;
   logic [N-1:0][DW-1:0]  wrData;
   logic [N-1:0]          gnt, rdValid;
   logic [DW-1:0]         rdData, memWrData, memRdData;
   logic [AW-1:0]         memAddr;
   logic                  memWrEn;

   logic                  pre_we;
   logic [AW-1:0]         pre_addr;
   logic [DW-1:0]         pre_data;
   logic [DW-1:0]         mem [0:4095];

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .CORE_COUNT (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LOCK_MAX   (LM)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .req       (req),
      .lock      (lock),
      .wrEn      (wrEn),
      .addr      (addr),
      .wrData    (wrData),
      .gnt       (gnt),
      .rdValid   (rdValid),
      .rdData    (rdData),
      .memAddr   (memAddr),
      .memWrData (memWrData),
      .memWrEn   (memWrEn),
      .memRdData (memRdData)
   );

   // Synchronous-read data memory with a bench backdoor write port.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (memWrEn) mem[memAddr] <= memWrData;
      memRdData <= mem[memAddr];
   end

   task automatic idle_inputs();
      req = '0; lock = '0; wrEn = '0; addr = '0; wrData = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstN = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstN = 1'b0;
      req = '1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++;
         if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b want 000", c, gnt); end
         n_cmp++;
         if (memWrEn !== 1'b0 || memAddr !== '0) begin n_fail++; $display("FAIL reset_mem[%0d]: got we=%b addr=%h want 0/000", c, memWrEn, memAddr); end
         n_cmp++;
         if (rdValid !== 3'b000) begin n_fail++; $display("FAIL reset_rdvalid[%0d]: got %b want 000", c, rdValid); end
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [6];
      exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rstN = 1'b1;
      req = '1; lock = '0; wrEn = '0;
      for (int c = 0; c < 6; c++) begin
         #2;
         n_cmp++;
         if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_seq[c]); end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_read();
      pre_we = 1'b1; pre_addr = 12'h05A; pre_data = 12'h3C7;
      @(negedge clk);
      do_reset();
      req[1] = 1'b1; addr[1] = 12'h05A; wrEn[1] = 1'b0;
      #2;
      n_cmp++;
      if (gnt !== 3'b010 || memAddr !== 12'h05A || memWrEn !== 1'b0) begin
         n_fail++; $display("FAIL read_grant: got gnt=%b addr=%h we=%b want 010/05a/0", gnt, memAddr, memWrEn);
      end
      @(negedge clk);
      req = '0;
      #2;
      n_cmp++;
      if (rdValid !== 3'b010 || rdData !== 12'h3C7) begin
         n_fail++; $display("FAIL read_return: got rdValid=%b rdData=%h want 010/3c7", rdValid, rdData);
      end
      @(negedge clk);
      #2;
      n_cmp++;
      if (rdValid !== 3'b000 || rdData !== 12'h000) begin
         n_fail++; $display("FAIL read_idle: got rdValid=%b rdData=%h want 000/000", rdValid, rdData);
      end
      @(negedge clk);
   endtask

   task automatic test_lock();
      logic [N-1:0] exp_seq [6];
      exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
      do_reset();
      req = 3'b101; lock = 3'b001; wrEn = '0;
      for (int c = 0; c < 6; c++) begin
         #2;
         n_cmp++;
         if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b want %b", c, gnt, exp_seq[c]); end
         @(negedge clk);
         if (c == 4) req[2] = 1'b0;
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_write_then_read();
      do_reset();
      req[2] = 1'b1; wrEn[2] = 1'b1; addr[2] = 12'h010; wrData[2] = 12'hABC;
      #2;
      n_cmp++;
      if (gnt !== 3'b100 || memWrEn !== 1'b1 || memAddr !== 12'h010 || memWrData !== 12'hABC) begin
         n_fail++; $display("FAIL wr_issue: got gnt=%b we=%b addr=%h wd=%h want 100/1/010/abc", gnt, memWrEn, memAddr, memWrData);
      end
      @(negedge clk);
      idle_inputs();
      req[0] = 1'b1; addr[0] = 12'h010;
      #2;
      n_cmp++;
      if (gnt !== 3'b001 || memWrEn !== 1'b0 || rdValid !== 3'b000) begin
         n_fail++; $display("FAIL rd_issue: got gnt=%b we=%b rdValid=%b want 001/0/000", gnt, memWrEn, rdValid);
      end
      @(negedge clk);
      req = '0;
      #2;
      n_cmp++;
      if (rdValid !== 3'b001 || rdData !== 12'hABC) begin
         n_fail++; $display("FAIL wr_rd_data: got rdValid=%b rdData=%h want 001/abc", rdValid, rdData);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      req = 3'b001; lock = 3'b001; addr[0] = 12'h020;
      #2;
      n_cmp++;
      if (gnt !== 3'b001) begin n_fail++; $display("FAIL rml_first: got %b want 001", gnt); end
      @(negedge clk);
      rstN = 1'b0;
      #2;
      n_cmp++;
      if (gnt !== 3'b000 || rdValid !== 3'b000 || memWrEn !== 1'b0) begin
         n_fail++; $display("FAIL rml_in_reset: got gnt=%b rdValid=%b we=%b want 000/000/0", gnt, rdValid, memWrEn);
      end
      @(negedge clk);
      rstN = 1'b1;
      req = 3'b011; lock = '0;
      #2;
      n_cmp++;
      if (gnt !== 3'b001 || rdValid !== 3'b000) begin
         n_fail++; $display("FAIL rml_after: got gnt=%b rdValid=%b want 001/000", gnt, rdValid);
      end
      @(negedge clk);
      // Second pass: the lock itself must be gone after reset.
      do_reset();
      req = 3'b001; lock = 3'b001;
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      req = 3'b010; lock = '0;
      #2;
      n_cmp++;
      if (gnt !== 3'b010) begin n_fail++; $display("FAIL rml_lock_dropped: got %b want 010", gnt); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_random();
      logic [DW-1:0] shadow [16];
      bit            pend [N];
      bit            p_we [N];
      logic [AW-1:0] p_addr [N];
      logic [DW-1:0] p_data [N];
      int            m_ptr, m_own, m_cnt, w, c;
      bit            m_lk;
      logic [N-1:0]  exp_gnt, exp_rv;
      logic [DW-1:0] exp_rd, exp_wd;
      logic [AW-1:0] exp_addr;
      logic          exp_we;

      do_reset();
      for (int a = 0; a < 16; a++) begin
         pre_we = 1'b1; pre_addr = AW'(a); pre_data = DW'($urandom);
         shadow[a] = pre_data;
         @(negedge clk);
      end
      pre_we = 1'b0;
      @(negedge clk);

      m_ptr = 0; m_lk = 0; m_own = 0; m_cnt = 0;
      exp_rv = '0; exp_rd = '0;
      for (int k = 0; k < N; k++) pend[k] = 0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 1) == 1) begin
               pend[k]   = 1;
               p_we[k]   = ($urandom_range(0, 2) == 0);
               p_addr[k] = AW'($urandom_range(0, 15));
               p_data[k] = DW'($urandom);
            end
            req[k]    = pend[k];
            lock[k]   = ($urandom_range(0, 3) != 0);
            wrEn[k]   = p_we[k];
            addr[k]   = p_addr[k];
            wrData[k] = p_data[k];
         end

         w = -1;
         if (!m_lk) begin
            for (int i = 0; i < N; i++) begin
               c = (m_ptr + i) % N;
               if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) begin
               m_ptr = (w + 1) % N;
               if (lock[w] && LM > 1) begin m_lk = 1; m_own = w; m_cnt = 1; end
            end
         end else if (req[m_own]) begin
            w = m_own;
            m_cnt++;
            if (!lock[m_own] || m_cnt >= LM) m_lk = 0;
         end else begin
            m_lk = 0;
         end

         exp_gnt = '0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
         if (w >= 0) begin
            exp_gnt[w] = 1'b1; exp_we = p_we[w]; exp_addr = p_addr[w]; exp_wd = p_data[w];
         end

         #2;
         n_cmp++;
         if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, gnt, exp_gnt); end
         n_cmp++;
         if (memWrEn !== exp_we || memAddr !== exp_addr || memWrData !== exp_wd) begin
            n_fail++; $display("FAIL rnd_mem[%0d]: got %b/%h/%h want %b/%h/%h", cyc, memWrEn, memAddr, memWrData, exp_we, exp_addr, exp_wd);
         end
         n_cmp++;
         if (rdValid !== exp_rv || rdData !== exp_rd) begin
            n_fail++; $display("FAIL rnd_rd[%0d]: got %b/%h want %b/%h", cyc, rdValid, rdData, exp_rv, exp_rd);
         end

         exp_rv = '0; exp_rd = '0;
         if (w >= 0) begin
            pend[w] = 0;
            if (p_we[w]) begin
               shadow[p_addr[w][3:0]] = p_data[w];
            end else begin
               exp_rv[w] = 1'b1;
               exp_rd    = shadow[p_addr[w][3:0]];
            end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rstN = 1'b0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_read();
      test_lock();
      test_write_then_read();
      test_reset_mid_lock();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
